multdiv: RTL and testbench
==========================

Name: multdiv

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- The instruction decoder selects this unit for R-type instructions whose aluop field is MUL or DIV.
- The decoder pulses a start strobe. The pipeline stalls on busy until data_resultRDY.
- The registered result and exception flag then go to the register-file write path.

Parameters:
WIDTH  32  operand/result width; iteration count per operation

Ports:
clock  input  1  sole clock, rising-edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
ctrl_MULT  input  1  start signed multiply; sampled on rising edge
ctrl_DIV  input  1  start signed divide; sampled on rising edge
data_operandA  input  WIDTH  multiplicand / dividend; sampled with start
data_operandB  input  WIDTH  multiplier / divisor; sampled with start
data_result  output  WIDTH  registered result, held until next start accepted
data_exception  output  1  registered overflow / divide-by-zero flag, held with result
data_resultRDY  output  1  one-cycle pulse: result and exception valid
busy  output  1  high while an operation is in flight (stall request)

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (reset=0), asynchronous: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0. All outputs stay at these values until reset=1 and a start is accepted.
- States: IDLE, MUL, DIV, FIX, DONE.
- Start: on a rising edge with ctrl_MULT=1 or ctrl_DIV=1:
  - latch both operands and their signs, counter=0;
  - enter MUL (ctrl_MULT) or DIV (ctrl_DIV);
  - if both strobes are high, MUL wins.
  - A start is accepted in any state, including mid-operation: the current operation is aborted, no RDY is emitted for it, and data_result/data_exception are unchanged until the new one completes.
- MUL: unsigned magnitude shift-add, one multiplier bit per edge, 2*WIDTH-bit accumulator. After WIDTH iterations go to FIX.
- DIV: unsigned magnitude restoring division, one quotient bit per edge. After WIDTH iterations go to FIX.
- FIX, one edge: apply sign, compute exception, write data_result/data_exception, go to DONE.
  - Multiply: result = low WIDTH bits of signed product. exception=1 iff the full 2*WIDTH product is not the sign-extension of its low WIDTH bits.
  - Divide: quotient truncated toward zero. Remainder is discarded.
  - Divisor=0: result=0, exception=1. Divide still takes the full latency; no early exit.
  - Dividend=-2^(WIDTH-1) with divisor=-1: result=0x80000000, exception=1.
- DONE: data_resultRDY=1 for exactly this cycle. Next edge goes to IDLE unless a new start is sampled on that edge.
- Latency: start sampled on edge E0. RDY is high during the cycle after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32.
- busy=1 in MUL, DIV, FIX; 0 in IDLE and DONE.
- Operand inputs are ignored after the start edge and may change freely.
- Counter is log2(WIDTH)+1 bits and never wraps: the terminal count forces the transition to FIX.

Decomposition:
- Shared package:
  - aluop constants ALUOP_MUL=5'b00110, ALUOP_DIV=5'b00111, R-type opcode 5'b00000, so the decoder and this block agree on encodings;
  - default WIDTH;
  - state encoding localparams.
- One natural sub-module, div_step: combinational single restoring-division iteration.
  - Inputs: partial remainder, divisor magnitude, next dividend bit.
  - Outputs: new remainder, quotient bit.
- Multiplier iteration stays inline.

Test Plan:
1. Reset=1, ctrl_MULT pulse, A=7, B=-3 (0xFFFFFFFD) -> RDY exactly 33 cycles after the start edge and one cycle wide; data_result=0xFFFFFFEB, data_exception=0; busy high for cycles 1-32.
2. MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1. MULT A=0xFFFFFFFF, B=0xFFFFFFFF -> result=1, exception=0.
3. DIV A=-7 (0xFFFFFFF9), B=2 -> result=0xFFFFFFFD, exception=0. DIV A=100, B=7 -> result=14.
4. DIV A=5, B=0 -> result=0, exception=1 at full latency. DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
5. Abort/restart: MULT 3*4, then ctrl_DIV with 100/7 ten cycles later -> single RDY, 33 cycles after the second start, result=14; no RDY or result=12 ever appears.
6. Simultaneous ctrl_MULT=ctrl_DIV=1 with A=6, B=3 -> result=18. Then reset=0 asserted mid-operation -> all outputs 0 immediately; after reset=1 with no start, no RDY for 100 cycles.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared encodings for the multiply/divide unit and the decoder that selects it.
package multdiv_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [4:0] OPC_RTYPE = 5'b00000;
   localparam logic [4:0] ALUOP_MUL = 5'b00110;
   localparam logic [4:0] ALUOP_DIV = 5'b00111;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_MUL  = ST_MUL,
      S_DIV  = ST_DIV,
      S_FIX  = ST_FIX,
      S_DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in a dividend
// bit, subtract the divisor when it fits, and emit the quotient bit.
module multdiv_div_step
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // A clear top bit of the difference means the divisor fit into the trial remainder.
   always_comb begin
      trial = {rem_i, bit_i};
      diff  = trial - {1'b0, div_i};
      q_o   = ~diff[WIDTH];
      rem_o = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply/divide: magnitudes are processed one bit per clock
// in a shared 2*WIDTH accumulator, then the sign and exception are applied.
module multdiv
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]        result_q, result_d;
   logic                    exc_q, exc_d;

   logic [2*WIDTH-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]        bmag_q, bmag_d;
   logic                    neg_q, neg_d;
   logic                    bzero_q, bzero_d;
   logic                    ovf_q, ovf_d;
   logic                    is_div_q, is_div_d;

   logic                    start, last;
   logic [WIDTH-1:0]        a_mag, b_mag;
   logic [WIDTH:0]          mul_sum;
   logic [WIDTH-1:0]        div_rem;
   logic                    div_q;
   logic signed [2*WIDTH-1:0] prod_s;
   logic signed [WIDTH-1:0]   quot_s;
   logic [WIDTH:0]          prod_hi;

   multdiv_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i (acc_q[2*WIDTH-1:WIDTH]),
      .div_i (bmag_q),
      .bit_i (acc_q[WIDTH-1]),
      .rem_o (div_rem),
      .q_o   (div_q)
   );

   always_comb begin
      start   = ctrl_MULT | ctrl_DIV;
      last    = (cnt_q == CNT_W'(WIDTH - 1));
      a_mag   = data_operandA[WIDTH-1] ? ({WIDTH{1'b0}} - data_operandA) : data_operandA;
      b_mag   = data_operandB[WIDTH-1] ? ({WIDTH{1'b0}} - data_operandB) : data_operandB;
      // Right-shifting accumulator: multiplier bits leave the bottom as partial sums enter the top.
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? bmag_q : {WIDTH{1'b0}})};
      prod_s  = neg_q ? -$signed(acc_q) : $signed(acc_q);
      quot_s  = neg_q ? -$signed(acc_q[WIDTH-1:0]) : $signed(acc_q[WIDTH-1:0]);
      prod_hi = prod_s[2*WIDTH-1:WIDTH-1];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      exc_d    = exc_q;
      acc_d    = acc_q;
      bmag_d   = bmag_q;
      neg_d    = neg_q;
      bzero_d  = bzero_q;
      ovf_d    = ovf_q;
      is_div_d = is_div_q;

      case (state_q)
         S_MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (last) state_d = S_FIX;
         end
         S_DIV: begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_q};
            cnt_d = cnt_q + CNT_W'(1);
            if (last) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_DONE;
            if (!is_div_q) begin
               result_d = prod_s[WIDTH-1:0];
               exc_d    = ~((&prod_hi) | ~(|prod_hi));
            end else if (bzero_q) begin
               result_d = {WIDTH{1'b0}};
               exc_d    = 1'b1;
            end else begin
               result_d = quot_s;
               exc_d    = ovf_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A new start aborts whatever is in flight and leaves the visible result untouched.
      if (start) begin
         state_d  = ctrl_MULT ? S_MUL : S_DIV;
         cnt_d    = {CNT_W{1'b0}};
         result_d = result_q;
         exc_d    = exc_q;
         acc_d    = {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
         bmag_d   = ctrl_MULT ? a_mag : b_mag;
         neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         bzero_d  = (data_operandB == {WIDTH{1'b0}});
         ovf_d    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
         is_div_d = ~ctrl_MULT;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         result_q <= {WIDTH{1'b0}};
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   always_ff @(posedge clock) begin
      acc_q    <= acc_d;
      bmag_q   <= bmag_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      ovf_q    <= ovf_d;
      is_div_q <= is_div_d;
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == S_DONE);
   assign busy           = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: latency, handshake and signed results for hand-computed vectors.
module tb_multdiv;

   logic        clock;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int passes = 0;
   int total  = 0;

   int lat, rdycnt, busybad, saw12, early;

   multdiv dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Observes 45 cycles after a start edge; records the first RDY cycle index.
   task automatic wait_done();
      lat = 0; rdycnt = 0; busybad = 0; saw12 = 0;
      for (int n = 1; n <= 45; n++) begin
         @(posedge clock);
         #1;
         if (n <= 32 && busy !== 1'b1) busybad++;
         if (data_resultRDY === 1'b1 && busy !== 1'b0) busybad++;
         if (data_result === 32'd12) saw12++;
         if (data_resultRDY === 1'b1) begin
            rdycnt++;
            if (lat == 0) lat = n;
         end
      end
   endtask

   task automatic run_check(input string tag, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_exc);
      start_op(m, d, a, b);
      wait_done();
      chk({tag, "_lat"}, lat, 32'd33);
      chk({tag, "_rdycnt"}, rdycnt, 32'd1);
      chk({tag, "_busy"}, busybad, 32'd0);
      chk({tag, "_res"}, data_result, exp_res);
      chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
   endtask

   initial begin
      reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = 32'd0; data_operandB = 32'd0;
      #1;
      chk("rst_res", data_result, 32'd0);
      chk("rst_exc", {31'd0, data_exception}, 32'd0);
      chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      // Multiply
      run_check("mul_7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
      run_check("mul_ovf", 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
      run_check("mul_m1m1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);

      // Divide
      run_check("div_m7d2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
      run_check("div_100d7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
      run_check("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
      run_check("div_ovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);

      // Abort a multiply with a divide ten cycles later
      start_op(1'b1, 1'b0, 32'd3, 32'd4);
      early = 0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1) early++;
         if (data_result === 32'd12) early++;
      end
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      wait_done();
      chk("abort_early", early, 32'd0);
      chk("abort_lat", lat, 32'd33);
      chk("abort_rdycnt", rdycnt, 32'd1);
      chk("abort_no12", saw12, 32'd0);
      chk("abort_res", data_result, 32'd14);

      // Both strobes: multiply wins
      run_check("both_6x3", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);

      // Asynchronous reset mid-operation
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      repeat (5) @(posedge clock);
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_res", data_result, 32'd0);
      chk("arst_exc", {31'd0, data_exception}, 32'd0);
      chk("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      rdycnt = 0; busybad = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY !== 1'b0) rdycnt++;
         if (busy !== 1'b0) busybad++;
      end
      chk("post_rst_rdy", rdycnt, 32'd0);
      chk("post_rst_busy", busybad, 32'd0);
      chk("post_rst_res", data_result, 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
